// File: rtl/memory_game_core_if.sv
// rtl/memory_game_core_if.sv - keypad and sequence-provider handshake bundle
interface memory_game_core_if #(
  parameter int MAX_LEN = 8
);
  logic                   key_valid;
  logic [3:0]             key_code;
  logic [4*MAX_LEN-1:0]   seq_in;
  logic                   seq_req;

  modport master (output key_valid, key_code, seq_in, input seq_req);
  modport slave  (input key_valid, key_code, seq_in, output seq_req);
endinterface

// File: rtl/memory_game_core.sv
// rtl/memory_game_core.sv - keypad memory game round/lives/score controller
module memory_game_core #(
  parameter int MAX_LEN   = 8,
  parameter int START_LEN = 4,
  parameter int LEVEL_UP  = 3,
  parameter int LIVES     = 3,
  parameter int SHOW_EASY = 7000000,
  parameter int SHOW_MED  = 5000000,
  parameter int SHOW_HARD = 3000000,
  parameter int TIMEOUT   = 50000000,
  parameter int SCORE_W   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_game_core_if.slave    kp,
  output logic                 show_number,
  output logic [4*MAX_LEN-1:0] disp_seq,
  output logic [3:0]           disp_len,
  output logic [3:0]           entry_count,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives_left,
  output logic [2:0]           state,
  output logic                 round_ok,
  output logic                 round_fail
);
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_SHOW = 3'd1, S_INPUT = 3'd2, S_OVER = 3'd3} state_t;

  localparam logic [3:0]  START4  = 4'(START_LEN);
  localparam logic [3:0]  MAX4    = 4'(MAX_LEN);
  localparam logic [2:0]  LIVES3  = 3'(LIVES);
  localparam logic [7:0]  LVL8    = 8'(LEVEL_UP);
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [1:0]             diff_q, diff_d;
  logic [31:0]            timer_q, timer_d, to_q, to_d, show_cycles;
  logic [4*MAX_LEN-1:0]   seq_q, seq_d, seq_shift;
  logic [3:0]             len_q, len_d, ec_q, ec_d, exp_idx, exp_digit;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [2:0]             lives_q, lives_d;
  logic [7:0]             streak_q, streak_d;
  logic                   ok_q, ok_d, fail_q, fail_d, show_q;
  logic                   req, win, miss;

  // Digits above the active length are zeroed so the overlay never shows stale data.
  function automatic logic [4*MAX_LEN-1:0] mask_seq(input logic [4*MAX_LEN-1:0] s, input logic [3:0] n);
    logic [4*MAX_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(n)) r[4*i +: 4] = s[4*i +: 4];
    return r;
  endfunction

  always_comb begin
    case (diff_q)
      2'd2:    show_cycles = 32'(SHOW_MED);
      2'd3:    show_cycles = 32'(SHOW_HARD);
      default: show_cycles = 32'(SHOW_EASY);
    endcase
  end

  // Most significant digit is entered first.
  assign exp_idx   = len_q - ec_q - 4'd1;
  assign seq_shift = seq_q >> {exp_idx, 2'b00};
  assign exp_digit = seq_shift[3:0];

  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    timer_d  = timer_q;
    to_d     = to_q;
    seq_d    = seq_q;
    len_d    = len_q;
    ec_d     = ec_q;
    score_d  = score_q;
    lives_d  = lives_q;
    streak_d = streak_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    req      = 1'b0;
    win      = 1'b0;
    miss     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (kp.key_valid) begin
          if (kp.key_code inside {4'd1, 4'd2, 4'd3}) begin
            diff_d = kp.key_code[1:0];
          end else if (kp.key_code == 4'd15) begin
            req      = 1'b1;
            len_d    = START4;
            seq_d    = mask_seq(kp.seq_in, START4);
            lives_d  = LIVES3;
            score_d  = '0;
            streak_d = '0;
            timer_d  = show_cycles;
            state_d  = S_SHOW;
          end
        end
      end
      S_SHOW: begin
        if (timer_q <= 32'd1) begin
          state_d = S_INPUT;
          ec_d    = '0;
          to_d    = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_INPUT: begin
        if (kp.key_valid) begin
          to_d = '0;
          if (kp.key_code <= 4'd9) begin
            if (kp.key_code == exp_digit) begin
              ec_d = ec_q + 4'd1;
              win  = (ec_q + 4'd1 == len_q);
            end else begin
              miss = 1'b1;
            end
          end else if (kp.key_code == 4'd14) begin
            ec_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          if (to_q == TO_LAST) miss = 1'b1;
          else                 to_d = to_q + 32'd1;
        end
      end
      S_OVER: begin
        if (kp.key_valid && kp.key_code == 4'd15) begin
          state_d = S_IDLE;
          lives_d = LIVES3;
          len_d   = START4;
          ec_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (win) begin
      ok_d = 1'b1;
      req  = 1'b1;
      if (score_q != '1) score_d = score_q + 1'b1;
      if (streak_q + 8'd1 >= LVL8) begin
        streak_d = '0;
        if (len_q < MAX4) len_d = len_q + 4'd1;
      end else begin
        streak_d = streak_q + 8'd1;
      end
      seq_d   = mask_seq(kp.seq_in, len_d);
      timer_d = show_cycles;
      state_d = S_SHOW;
    end

    // A miss replays the same sequence without asking the provider for a new one.
    if (miss) begin
      fail_d   = 1'b1;
      lives_d  = lives_q - 3'd1;
      streak_d = '0;
      if (lives_q == 3'd1) begin
        state_d = S_OVER;
      end else begin
        state_d = S_SHOW;
        timer_d = show_cycles;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      diff_q   <= 2'd1;
      timer_q  <= '0;
      to_q     <= '0;
      seq_q    <= '0;
      len_q    <= START4;
      ec_q     <= '0;
      score_q  <= '0;
      lives_q  <= LIVES3;
      streak_q <= '0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      diff_q   <= diff_d;
      timer_q  <= timer_d;
      to_q     <= to_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      ec_q     <= ec_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      streak_q <= streak_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
      show_q   <= (state_d == S_SHOW);
    end
  end

  assign kp.seq_req  = req & ~rst;
  assign show_number = show_q;
  assign disp_seq    = seq_q;
  assign disp_len    = len_q;
  assign entry_count = ec_q;
  assign score       = score_q;
  assign lives_left  = lives_q;
  assign state       = state_q;
  assign round_ok    = ok_q;
  assign round_fail  = fail_q;
endmodule
